// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: PID codes, SYNC pattern, CRC16 constants and FSM states.
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  // Bit 0 goes on the wire first: seven 0s then a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_t;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16_ser.sv
// Serial CRC16 over an LSB-first bit stream; register bit 0 holds the x^15 term so the
// complemented output is shifted onto the wire LSB first.
module usb_crc16_ser
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  logic [15:0] crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= (crc >> 1) ^ (((crc[0] ^ bit_in) == 1'b1) ? POLY_REFL : 16'h0000);
    end
  end

  assign crc_out = ~crc;

endmodule

// File: rtl/usb_tx_packet.sv
// Bit-serial USB packet transmitter: SYNC, PID, optional payload + CRC16, bit stuffing, EOP.
// Optional USB_TX_AUTO_TOGGLE_EN replaces bit 3 of data PIDs with an internal DATA0/DATA1 toggle.
module usb_tx_packet
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int EOP_BITS  = 3,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             useClk,
  input  logic             nReset,
  input  logic             checkData,
  input  logic             startReq,
  input  logic [3:0]       pidCode,
  input  logic [CNT_W-1:0] byteCount,
  input  logic [7:0]       txByte,
  input  logic             txByteValid,
`ifdef USB_TX_AUTO_TOGGLE_EN
  input  logic             toggleClr,
`endif
  output logic             txByteReady,
  output logic             txBit,
  output logic             txOe,
  output logic             txEop,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam logic [7:0]       EOP_LAST = 8'(EOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BYTES);

  tx_state_t        state, state_nxt;
  logic [7:0]       idx, idx_nxt;
  logic [2:0]       ones_cnt;
  logic [3:0]       pid_q, pid_eff;
  logic [7:0]       pid_byte;
  logic             is_data_q;
  logic [CNT_W-1:0] bytes_left, cnt_clamped;
  logic [7:0]       data_sr;
  logic [15:0]      crc_out;
  logic             stuff_now, seg_last, start, want_byte, load_byte, underrun_nxt, finish;
  logic             bit_nxt, oe_nxt, eop_nxt, crc_en;

`ifdef USB_TX_AUTO_TOGGLE_EN
  logic toggle, underrun_seen;

  assign pid_eff = is_data_pid(pidCode) ? {toggle, pidCode[2:0]} : pidCode;

  always_ff @(posedge useClk or negedge nReset) begin
    if (!nReset) begin
      toggle        <= 1'b0;
      underrun_seen <= 1'b0;
    end else if (checkData) begin
      if (toggleClr) begin
        toggle <= 1'b0;
      end else if (finish && is_data_q && !underrun_seen) begin
        toggle <= ~toggle;
      end
      if (start) begin
        underrun_seen <= 1'b0;
      end else if (underrun_nxt) begin
        underrun_seen <= 1'b1;
      end
    end
  end
`else
  assign pid_eff = pidCode;
`endif

  assign cnt_clamped = (byteCount > CNT_MAX) ? CNT_MAX : byteCount;
  assign pid_byte    = {~pid_q, pid_q};
  // Six 1s in a row force a 0 into the next slot; the source stream holds its position.
  assign stuff_now   = (ones_cnt == 3'd6) && (state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC});

  always_comb begin
    seg_last = 1'b0;
    case (state)
      ST_SYNC, ST_PID, ST_DATA: seg_last = (idx == 8'd7);
      ST_CRC:                   seg_last = (idx == 8'd15);
      ST_EOP:                   seg_last = (idx == EOP_LAST);
      default:                  seg_last = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    start        = 1'b0;
    want_byte    = 1'b0;
    load_byte    = 1'b0;
    underrun_nxt = 1'b0;
    finish       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (startReq) begin
          start     = 1'b1;
          state_nxt = ST_SYNC;
          idx_nxt   = 8'd0;
        end
      end
      ST_EOP: begin
        if (seg_last) begin
          state_nxt = ST_IDLE;
          idx_nxt   = 8'd0;
          finish    = 1'b1;
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      default: begin
        if (stuff_now) begin
          state_nxt = state;
        end else if (!seg_last) begin
          idx_nxt = idx + 8'd1;
        end else begin
          idx_nxt = 8'd0;
          case (state)
            ST_SYNC: state_nxt = ST_PID;
            ST_PID: begin
              if (!is_data_q)           state_nxt = ST_EOP;
              else if (bytes_left != 0) want_byte = 1'b1;
              else                      state_nxt = ST_CRC;
            end
            ST_DATA: begin
              if (bytes_left != 0) want_byte = 1'b1;
              else                 state_nxt = ST_CRC;
            end
            default: state_nxt = ST_EOP;
          endcase
        end
      end
    endcase
    // A missing byte abandons the payload and closes the packet without CRC.
    if (want_byte) begin
      if (txByteValid) begin
        state_nxt = ST_DATA;
        load_byte = 1'b1;
      end else begin
        state_nxt    = ST_EOP;
        underrun_nxt = 1'b1;
      end
    end
  end

  // Output decode: the bit to present after this strobe.
  always_comb begin
    bit_nxt = 1'b0;
    oe_nxt  = 1'b1;
    eop_nxt = 1'b0;
    crc_en  = 1'b0;
    if (!stuff_now) begin
      case (state_nxt)
        ST_IDLE: oe_nxt = 1'b0;
        ST_SYNC: bit_nxt = SYNC_PATTERN[idx_nxt[2:0]];
        ST_PID:  bit_nxt = pid_byte[idx_nxt[2:0]];
        ST_DATA: begin
          bit_nxt = load_byte ? txByte[0] : data_sr[idx_nxt[2:0]];
          crc_en  = 1'b1;
        end
        ST_CRC:  bit_nxt = crc_out[idx_nxt[3:0]];
        default: eop_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge useClk or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      idx         <= 8'd0;
      ones_cnt    <= 3'd0;
      pid_q       <= 4'd0;
      is_data_q   <= 1'b0;
      bytes_left  <= '0;
      data_sr     <= 8'd0;
      txBit       <= 1'b0;
      txOe        <= 1'b0;
      txEop       <= 1'b0;
      busy        <= 1'b0;
      txByteReady <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      txByteReady <= checkData & load_byte;
      done        <= checkData & finish;
      underrun    <= checkData & underrun_nxt;
      if (checkData) begin
        state    <= state_nxt;
        idx      <= idx_nxt;
        txBit    <= bit_nxt;
        txOe     <= oe_nxt;
        txEop    <= eop_nxt;
        busy     <= (state_nxt != ST_IDLE);
        ones_cnt <= (bit_nxt && state_nxt != ST_EOP && state_nxt != ST_IDLE) ?
                    ones_cnt + 3'd1 : 3'd0;
        if (start) begin
          pid_q      <= pid_eff;
          is_data_q  <= is_data_pid(pidCode);
          bytes_left <= is_data_pid(pidCode) ? cnt_clamped : '0;
        end
        if (load_byte) begin
          data_sr    <= txByte;
          bytes_left <= bytes_left - CNT_W'(1);
        end
      end
    end
  end

  usb_crc16_ser u_crc (
    .clk     (useClk),
    .rst_n   (nReset),
    .en      (checkData & crc_en),
    .clr     (checkData & start),
    .bit_in  (bit_nxt),
    .crc_out (crc_out)
  );

endmodule

// File: tb/tb_usb_tx_packet.sv
// Bench for usb_tx_packet: directed and random packets against a bit-stream reference model.
module tb_usb_tx_packet;
  import usb_pkg::*;

  localparam int MAX_BYTES = 8;
  localparam int EOP_BITS  = 3;
  localparam int CNT_W     = 4;

  logic             useClk, nReset, checkData, startReq, txByteValid;
  logic [3:0]       pidCode;
  logic [CNT_W-1:0] byteCount;
  logic [7:0]       txByte;
  logic             txByteReady, txBit, txOe, txEop, busy, done, underrun;
`ifdef USB_TX_AUTO_TOGGLE_EN
  logic             toggleClr;
`endif

  usb_tx_packet #(.MAX_BYTES(MAX_BYTES), .EOP_BITS(EOP_BITS), .CNT_W(CNT_W)) dut (
    .useClk      (useClk),
    .nReset      (nReset),
    .checkData   (checkData),
    .startReq    (startReq),
    .pidCode     (pidCode),
    .byteCount   (byteCount),
    .txByte      (txByte),
    .txByteValid (txByteValid),
`ifdef USB_TX_AUTO_TOGGLE_EN
    .toggleClr   (toggleClr),
`endif
    .txByteReady (txByteReady),
    .txBit       (txBit),
    .txOe        (txOe),
    .txEop       (txEop),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  always #5 useClk = ~useClk;

  int   vectors = 0, miscompares = 0;
  logic [7:0] bytes [16];
  bit   exp_bit[$], exp_eop[$];
  int   exp_rdy, exp_und, k, nvalid, rdy_cnt, und_cnt, done_cnt;
  bit   tog = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  // Reference stream: raw fields, CRC by polynomial long division, then stuffing.
  task automatic build(input logic [3:0] p, input int cnt, input int nv);
    bit s[$];
    int n, nl, ones;
    logic [15:0] crc;
    logic [7:0]  pb;
    s = {};
    exp_bit = {};
    exp_eop = {};
    for (int i = 0; i < 7; i++) s.push_back(1'b0);
    s.push_back(1'b1);
    pb = {~p, p};
    for (int i = 0; i < 8; i++) s.push_back(pb[i]);
    n  = is_data(p) ? ((cnt > MAX_BYTES) ? MAX_BYTES : cnt) : 0;
    nl = (nv < n) ? nv : n;
    exp_und = (nv < n) ? 1 : 0;
    exp_rdy = nl;
    crc = 16'hFFFF;
    for (int b = 0; b < nl; b++) begin
      for (int i = 0; i < 8; i++) begin
        s.push_back(bytes[b][i]);
        crc = {crc[14:0], 1'b0} ^ (((crc[15] ^ bytes[b][i]) == 1'b1) ? 16'h8005 : 16'h0000);
      end
    end
    if (is_data(p) && exp_und == 0)
      for (int i = 15; i >= 0; i--) s.push_back(~crc[i]);
    ones = 0;
    foreach (s[i]) begin
      exp_bit.push_back(s[i]);
      exp_eop.push_back(1'b0);
      ones = s[i] ? ones + 1 : 0;
      if (ones == 6) begin
        exp_bit.push_back(1'b0);
        exp_eop.push_back(1'b0);
        ones = 0;
      end
    end
    for (int i = 0; i < EOP_BITS; i++) begin
      exp_bit.push_back(1'b0);
      exp_eop.push_back(1'b1);
    end
  endtask

  task automatic strobe(input int gap);
    repeat (gap - 1) @(posedge useClk);
    @(negedge useClk);
    checkData = 1'b1;
    @(posedge useClk);
    #1;
    checkData = 1'b0;
    if (underrun) und_cnt++;
    if (done) done_cnt++;
    if (txByteReady) begin
      rdy_cnt++;
      k++;
      txByte      = bytes[k % 16];
      txByteValid = (k < nvalid);
    end
  endtask

  task automatic run_packet(input logic [3:0] pid, input int cnt, input int nv,
                            input bit hold_req, input int gap);
    logic [3:0] sent;
    sent = pid;
`ifdef USB_TX_AUTO_TOGGLE_EN
    if (is_data(pid)) sent = {tog, pid[2:0]};
`endif
    build(sent, cnt, nv);
    k = 0; nvalid = nv; rdy_cnt = 0; und_cnt = 0; done_cnt = 0;
    txByte = bytes[0];
    txByteValid = (nv > 0);
    pidCode = pid;
    byteCount = CNT_W'(cnt);
    startReq = 1'b1;
    for (int i = 0; i < exp_bit.size(); i++) begin
      strobe(gap);
      if (!hold_req) startReq = 1'b0;
      chk($sformatf("oe[%0d] pid%h", i, pid), txOe, 1);
      chk($sformatf("eop[%0d] pid%h", i, pid), txEop, exp_eop[i]);
      chk($sformatf("busy[%0d]", i), busy, 1);
      if (!exp_eop[i]) chk($sformatf("bit[%0d] pid%h", i, pid), txBit, exp_bit[i]);
    end
    strobe(gap);
    startReq = 1'b0;
    chk("end_oe", txOe, 0);
    chk("end_eop", txEop, 0);
    chk("end_busy", busy, 0);
    chk("done_cnt", done_cnt, 1);
    chk("rdy_cnt", rdy_cnt, exp_rdy);
    chk("und_cnt", und_cnt, exp_und);
    if (is_data(pid) && exp_und == 0) tog = ~tog;
  endtask

  logic [3:0] pids [5];

  initial begin
    pids = '{PID_ACK, PID_NAK, PID_STALL, PID_DATA0, PID_DATA1};
    useClk = 0; nReset = 0; checkData = 0; startReq = 0; pidCode = 0;
    byteCount = 0; txByte = 0; txByteValid = 0;
`ifdef USB_TX_AUTO_TOGGLE_EN
    toggleClr = 0;
`endif
    repeat (3) @(posedge useClk);
    #1;
    chk("rst_txBit", txBit, 0);
    chk("rst_txOe", txOe, 0);
    chk("rst_txEop", txEop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", txByteReady, 0);
    @(negedge useClk);
    nReset = 1;

    run_packet(PID_ACK, 0, 0, 0, 4);
    run_packet(PID_DATA1, 0, 0, 0, 4);
    bytes[0] = 8'hFF;
    run_packet(PID_DATA0, 1, 1, 1, 4);
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    run_packet(PID_DATA0, 2, 1, 0, 4);
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
    run_packet(PID_DATA1, 15, 15, 0, 2);

    // Asynchronous reset in the middle of the payload.
    build(PID_DATA0, 4, 4);
    k = 0; nvalid = 4; txByte = bytes[0]; txByteValid = 1;
    pidCode = PID_DATA0; byteCount = 4; startReq = 1;
    strobe(3);
    startReq = 0;
    repeat (24) strobe(3);
    @(posedge useClk);
    #3;
    nReset = 0;
    #1;
    chk("mid_rst_oe", txOe, 0);
    chk("mid_rst_eop", txEop, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(posedge useClk);
    @(negedge useClk);
    nReset = 1;
    tog = 0;
    run_packet(PID_NAK, 0, 0, 0, 3);

`ifdef USB_TX_AUTO_TOGGLE_EN
    toggleClr = 1;
    strobe(2);
    toggleClr = 0;
    tog = 0;
    for (int r = 0; r < 3; r++) begin
      bytes[0] = 8'($urandom);
      run_packet(PID_DATA0, 1, 1, 0, 2);
    end
    toggleClr = 1;
    strobe(2);
    toggleClr = 0;
    tog = 0;
    run_packet(PID_DATA0, 1, 1, 0, 2);
`endif

    for (int r = 0; r < 14; r++) begin
      int cnt, nv;
      for (int i = 0; i < 16; i++) bytes[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      cnt = $urandom_range(0, 10);
      nv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt) : 16;
      run_packet(pids[$urandom_range(0, 4)], cnt, nv, $urandom_range(0, 1) == 1,
                 $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
